rand_range_sampler: RTL
=======================

// Module: rand_range_sampler
// PURPOSE
//   Downstream consumer of the 13-bit LFSR word from module rand: turns the free-running rnd bus into
//   uniformly distributed values in [0, limit) on demand. Uses mask-and-reject sampling, with a bounded
//   retry count and a deterministic fallback. Game logic (spawn position, enemy choice) issues a request,
//   then receives one value through a valid/ready handshake.
// PARAMETERS
//   RND_W      13  width of incoming rnd word (matches rand output)
//   OUT_W       8  width of limit and value; RND_W >= OUT_W required
//   MAX_TRIES   4  samples attempted before fallback; >= 1
// PORTS
//   clock      in   1      single clock, all logic on posedge
//   reset      in   1      synchronous, active-high
//   rnd        in   RND_W  LFSR word, new value every cycle
//   req_valid  in   1      request strobe; limit valid when high
//   limit      in   OUT_W  exclusive upper bound of requested value
//   req_ready  out  1      high only in IDLE
//   out_valid  out  1      value/fallback/err valid; held until out_ready
//   out_ready  in   1      consumer accepts result
//   value      out  OUT_W  sampled result
//   fallback   out  1      value produced by fallback path
//   err        out  1      request had limit == 0
// BEHAVIOUR
//   Reset: state=IDLE; out_valid=0, value=0, fallback=0, err=0, tries=0; req_ready=1 the cycle after reset drops.
//   FSM states: IDLE, SAMPLE, HOLD.
//   IDLE: req_valid&&req_ready (cycle 0) latches limit_q=limit and mask_q=smear(limit-1)
//     (smear = OR of all right shifts, i.e. next pow2 minus 1); tries=0; -> SAMPLE.
//     limit==0: value=0, err=1, fallback=0; -> HOLD directly (out_valid in cycle 1).
//   SAMPLE, each cycle: cand = rnd[OUT_W-1:0] & mask_q.
//     cand <  limit_q                  -> value=cand, fallback=0, -> HOLD
//     cand >= limit_q, tries==MAX_TRIES-1 -> value=cand-limit_q, fallback=1, -> HOLD
//     else tries=tries+1, stay in SAMPLE (rnd has shifted, so the next cycle takes a fresh sample).
//   Fallback is always < limit_q because cand <= mask_q < 2*limit_q. Subtraction is OUT_W bits, no wrap.
//   Latency: first-try accept -> out_valid in cycle 2; worst case out_valid in cycle MAX_TRIES+1.
//   HOLD: out_valid=1, value/fallback/err stable. out_ready -> IDLE, out_valid=0 next cycle.
//     No request bypass: a request arriving while out_ready is high is accepted no earlier than the following cycle.
//   req_valid is ignored outside IDLE (req_ready=0). limit changes after acceptance have no effect.
//   limit==1: mask_q=0, cand=0, always accepted on the first try.
//   Reset in any state overrides everything: IDLE and all outputs zero on the next edge.
//   Registered outputs only; req_ready decoded from state.
// STRUCTURE
//   Shared header rand_defs.vh: RND_W default (13), LFSR seed constant, FSM state encodings
//     (IDLE=2'd0, SAMPLE=2'd1, HOLD=2'd2), shared by rand and this block.
//   Sub-module range_mask (combinational, OUT_W param): limit -> mask = smear(limit-1); reused by other
//     bounded-random consumers.
//   Top: FSM, limit_q/mask_q/tries registers, compare/subtract datapath.
// TESTING (bench drives rnd directly; OUT_W=8, MAX_TRIES=4)
//   1 limit=10, rnd=0x0005 -> mask_q=0x0F; out_valid in cycle 2, value=5, fallback=0, err=0.
//   2 limit=10, rnd=0x000C,0x000F,0x0003 in cycles 1..3 -> two rejects; out_valid in cycle 4, value=3.
//   3 limit=10, rnd held 0x000E -> 4 rejects; out_valid in cycle 5, value=4, fallback=1.
//   4 limit=1, any rnd (0x1FFF) -> value=0 in cycle 2; limit=0 -> value=0, err=1, out_valid in cycle 1.
//   5 result pending, out_ready low 5 cycles with req_valid high -> value stable, req_ready=0;
//     out_ready=1 -> IDLE next cycle, new request accepted after that.
//   6 reset asserted during SAMPLE (after 2 rejects) -> next cycle IDLE, out_valid=0, value=0, req_ready=1
//     once reset drops; next request behaves as in test 1.

Source files
------------

// File: rtl/rand_range_sampler_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | rand_range_sampler_pkg : constants and FSM states shared by the rand    |
// | family of blocks.                                       Revision 1.0    |
// +------------------------------------------------------------------------+
package rand_range_sampler_pkg;

  localparam int          c_rnd_w_default = 13;
  localparam logic [12:0] c_lfsr_seed     = 13'h1ACE;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rand_range_sampler_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | rand_range_sampler_if : random word, request and result handshake.     |
// |                                                         Revision 1.0    |
// +------------------------------------------------------------------------+
interface rand_range_sampler_if #(
  parameter int RND_W = 13,
  parameter int OUT_W = 8
);
  logic [RND_W-1:0] rnd;
  logic             req_valid;
  logic [OUT_W-1:0] limit;
  logic             req_ready;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] value;
  logic             fallback;
  logic             err;

  modport master (
    output rnd, req_valid, limit, out_ready,
    input  req_ready, out_valid, value, fallback, err
  );

  modport slave (
    input  rnd, req_valid, limit, out_ready,
    output req_ready, out_valid, value, fallback, err
  );
endinterface
`default_nettype wire

// File: rtl/rand_range_sampler_mask.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | range_mask : limit -> all-ones mask covering limit-1 (next pow2 - 1).   |
// |                                                         Revision 1.0    |
// +------------------------------------------------------------------------+
module range_mask #(
  parameter int OUT_W = 8
) (
  input  logic [OUT_W-1:0] i_limit,
  output logic [OUT_W-1:0] o_mask
);
  logic [OUT_W-1:0] w_dec;

  assign w_dec = i_limit - 1'b1;

  always_comb begin
    o_mask = w_dec;
    for (int i = 1; i < OUT_W; i++) begin
      o_mask = o_mask | (w_dec >> i);
    end
  end
endmodule
`default_nettype wire

// File: rtl/rand_range_sampler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | rand_range_sampler : mask-and-reject sampling of [0, limit) from an     |
// | LFSR word, bounded retries with subtractive fallback.   Revision 1.0    |
// +------------------------------------------------------------------------+
module rand_range_sampler
  import rand_range_sampler_pkg::*;
#(
  parameter int RND_W     = c_rnd_w_default,
  parameter int OUT_W     = 8,
  parameter int MAX_TRIES = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  rand_range_sampler_if.slave  bus
);
  localparam int                 c_try_w    = $clog2(MAX_TRIES + 1);
  localparam logic [c_try_w-1:0] c_last_try = c_try_w'(MAX_TRIES - 1);

  state_t             r_state;
  logic [OUT_W-1:0]   r_limit_q;
  logic [OUT_W-1:0]   r_mask_q;
  logic [OUT_W-1:0]   r_value;
  logic [c_try_w-1:0] r_tries;
  logic               r_out_valid;
  logic               r_fallback;
  logic               r_err;

  logic [OUT_W-1:0]   w_mask;
  logic [OUT_W-1:0]   w_cand;
  logic [OUT_W-1:0]   w_wrapped;

  range_mask #(.OUT_W(OUT_W)) u_range_mask (
    .i_limit (bus.limit),
    .o_mask  (w_mask)
  );

  generate
    if (RND_W > OUT_W) begin : g_rnd_upper
      logic w_unused_rnd_upper;
      assign w_unused_rnd_upper = ^bus.rnd[RND_W-1:OUT_W];
    end
  endgenerate

  assign w_cand    = bus.rnd[OUT_W-1:0] & r_mask_q;
  // cand <= mask < 2*limit, so this never wraps when cand >= limit
  assign w_wrapped = w_cand - r_limit_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_limit_q   <= '0;
      r_mask_q    <= '0;
      r_value     <= '0;
      r_tries     <= '0;
      r_out_valid <= 1'b0;
      r_fallback  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_limit_q  <= bus.limit;
            r_mask_q   <= w_mask;
            r_tries    <= '0;
            r_fallback <= 1'b0;
            if (bus.limit == '0) begin
              r_value     <= '0;
              r_err       <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= ST_HOLD;
            end else begin
              r_err   <= 1'b0;
              r_state <= ST_SAMPLE;
            end
          end
        end
        ST_SAMPLE: begin
          if (w_cand < r_limit_q) begin
            r_value     <= w_cand;
            r_fallback  <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= ST_HOLD;
          end else if (r_tries == c_last_try) begin
            r_value     <= w_wrapped;
            r_fallback  <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= ST_HOLD;
          end else begin
            r_tries <= r_tries + 1'b1;
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = (r_state == ST_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.value     = r_value;
  assign bus.fallback  = r_fallback;
  assign bus.err       = r_err;
endmodule
`default_nettype wire
